// File: rtl/ddr3_axis_traffic_checker.sv
// Pattern source and checker for the DDR3 AXI-Stream FIFO loopback path.
// Writes a burst of pattern words, reads them back and counts mismatches.
module ddr3_axis_traffic_checker #(
  parameter int DATA_W      = 16,
  parameter int BURST_LEN   = 1024,
  parameter int NUM_PASSES  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  output logic              tx_tvaild,
  output logic [DATA_W-1:0] tx_tdata,
  input  logic              tx_tready,
  input  logic              rx_tvaild,
  input  logic [DATA_W-1:0] rx_tdata,
  output logic              rx_tready,
  output logic              busy,
  output logic              test_pass,
  output logic              test_fail,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [15:0]       pass_cnt
);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, DONE, FAIL
  } state_t;

  state_t      state;
  logic [31:0] idx;
  logic [31:0] wdog;

  logic tx_hs;
  logic rx_hs;
  logic last;
  logic mism;
  logic wd_exp;

  function automatic logic [DATA_W-1:0] pat(
    input logic [15:0] p,
    input logic [15:0] i
  );
    logic [15:0] w;
    w = p * 16'h0101 + i;
    return w[DATA_W-1:0];
  endfunction

  assign tx_hs  = tx_tvaild & tx_tready;
  assign rx_hs  = rx_tvaild & rx_tready;
  assign last   = (idx == 32'(BURST_LEN - 1));
  assign mism   = rx_hs &&
                  (rx_tdata != pat(pass_cnt, idx[15:0]));
  assign wd_exp = (TIMEOUT_CYC != 0) &&
                  (wdog == 32'(TIMEOUT_CYC - 1)) &&
                  !tx_hs && !rx_hs;
  assign busy   = (state == WRITE) || (state == READ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      wdog      <= '0;
      tx_tvaild <= 1'b0;
      tx_tdata  <= '0;
      rx_tready <= 1'b0;
      test_pass <= 1'b0;
      test_fail <= 1'b0;
      timeout   <= 1'b0;
      err_cnt   <= '0;
      pass_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (init_calib_complete) begin
            state <= WRITE;
            idx   <= '0;
            wdog  <= '0;
          end
        end
        WRITE: begin
          if (wd_exp) begin
            state     <= FAIL;
            timeout   <= 1'b1;
            test_fail <= 1'b1;
            test_pass <= 1'b0;
            tx_tvaild <= 1'b0;
            rx_tready <= 1'b0;
          end else begin
            wdog <= tx_hs ? '0 : wdog + 32'd1;
            if (!tx_tvaild) begin
              tx_tvaild <= 1'b1;
              tx_tdata  <= pat(pass_cnt, idx[15:0]);
            end else if (tx_hs) begin
              if (last) begin
                tx_tvaild <= 1'b0;
                idx       <= '0;
                wdog      <= '0;
                state     <= READ;
              end else begin
                idx      <= idx + 32'd1;
                tx_tdata <= pat(pass_cnt, idx[15:0] + 16'd1);
              end
            end
          end
        end
        READ: begin
          if (wd_exp) begin
            state     <= FAIL;
            timeout   <= 1'b1;
            test_fail <= 1'b1;
            test_pass <= 1'b0;
            tx_tvaild <= 1'b0;
            rx_tready <= 1'b0;
          end else begin
            wdog <= rx_hs ? '0 : wdog + 32'd1;
            if (!rx_tready) begin
              rx_tready <= 1'b1;
            end else if (rx_hs) begin
              if (mism) begin
                test_fail <= 1'b1;
                if (err_cnt != 16'hFFFF)
                  err_cnt <= err_cnt + 16'd1;
              end
              if (last) begin
                rx_tready <= 1'b0;
                idx       <= '0;
                wdog      <= '0;
                pass_cnt  <= pass_cnt + 16'd1;
                // last mismatch lands in err_cnt this same edge
                if (NUM_PASSES != 0 &&
                    pass_cnt + 16'd1 == 16'(NUM_PASSES)) begin
                  state     <= DONE;
                  test_pass <= (err_cnt == 16'd0) && !mism;
                end else begin
                  state <= WRITE;
                end
              end else begin
                idx <= idx + 32'd1;
              end
            end
          end
        end
        DONE, FAIL: begin
        end
      endcase
    end
  end

endmodule
